// File: rtl/riscv_regfile_sb.sv
// RISC-V integer register file: two combinational read ports, one write port,
// optional write-to-read bypass, per-register pending-write scoreboard, and a sequenced clear.
module riscv_regfile_sb #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(NREG)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clr_i,
  input  logic            wr_i,
  input  logic [AW-1:0]   rd0_i,
  input  logic [XLEN-1:0] rd0_value_i,
  input  logic            iss_i,
  input  logic [AW-1:0]   iss_rd_i,
  input  logic [AW-1:0]   ra0_i,
  input  logic [AW-1:0]   rb0_i,
  output logic [XLEN-1:0] ra0_value_o,
  output logic [XLEN-1:0] rb0_value_o,
  output logic            ra0_busy_o,
  output logic            rb0_busy_o,
  output logic            ready_o
);

  typedef enum logic {S_CLEAR = 1'b0, S_RUN = 1'b1} state_t;

  localparam logic [AW:0] CNT_LAST = (AW+1)'(NREG - 1);
  localparam logic [AW:0] CNT_ONE  = {{AW{1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [AW:0]       cnt_q, cnt_d;
  logic [NREG-1:0]   busy_q, busy_d;
  logic [XLEN-1:0]   mem [NREG];

  logic              mem_we;
  logic [AW-1:0]     mem_waddr;
  logic [XLEN-1:0]   mem_wdata;
  logic              wr_ok, iss_ok;

  // Writes and issues aimed at the hardwired zero register are dropped.
  assign wr_ok  = wr_i  && !(ZERO_REG != 0 && rd0_i == '0);
  assign iss_ok = iss_i && !(ZERO_REG != 0 && iss_rd_i == '0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    mem_we    = 1'b0;
    mem_waddr = rd0_i;
    mem_wdata = rd0_value_i;
    case (state_q)
      S_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q[AW-1:0];
        mem_wdata = '0;
        cnt_d     = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) state_d = S_RUN;
      end
      default: begin
        if (clr_i) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
          busy_d  = '0;
        end else begin
          mem_we = wr_ok;
          if (wr_ok)  busy_d[rd0_i]    = 1'b0;
          // Issue is applied after writeback so a same-index pair leaves the entry pending.
          if (iss_ok) busy_d[iss_rd_i] = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_CLEAR;
      cnt_q   <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  // Storage carries no reset so it can map onto a RAM macro.
  always_ff @(posedge clk_i) begin
    if (!rst_i && mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_comb begin
    ra0_value_o = '0;
    ra0_busy_o  = 1'b0;
    if (state_q == S_RUN && !(ZERO_REG != 0 && ra0_i == '0)) begin
      if (BYPASS != 0 && wr_i && rd0_i == ra0_i) begin
        ra0_value_o = rd0_value_i;
      end else begin
        ra0_value_o = mem[ra0_i];
        ra0_busy_o  = busy_q[ra0_i];
      end
    end
  end

  always_comb begin
    rb0_value_o = '0;
    rb0_busy_o  = 1'b0;
    if (state_q == S_RUN && !(ZERO_REG != 0 && rb0_i == '0)) begin
      if (BYPASS != 0 && wr_i && rd0_i == rb0_i) begin
        rb0_value_o = rd0_value_i;
      end else begin
        rb0_value_o = mem[rb0_i];
        rb0_busy_o  = busy_q[rb0_i];
      end
    end
  end

  assign ready_o = (state_q == S_RUN);

endmodule
